// File: rtl/pci_target_mem.sv
// PCI memory target: claims memory read/write cycles that hit a 2^DEPTH_LOG2-word window at BASE_ADDR.
// Optional macro PCI_TARGET_DISCONNECT_EN: disconnect with STOP at the window end instead of wrapping.
module pci_target_mem #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FRAME,
    inout  wire  [31:0] AD,
    input  logic [3:0]  CBE,
    input  logic        IRDY,
    output logic        TRDY,
    output logic        DEVSEL,
    output logic        STOP
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] LAST_INDEX = '1;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        RD_TURN,
        RD_DATA,
        DISC,
        TURN
    } state_t;

    state_t                state_reg;
    logic [DEPTH_LOG2-1:0] index_reg;
    logic [DEPTH_LOG2-1:0] index_next;
    logic                  frame_prev_reg;
    logic                  trdy_reg;
    logic                  devsel_reg;
    logic                  ad_oe_reg;
    logic [31:0]           rd_word;

    logic addr_phase;
    logic addr_hit;
    logic cmd_write;
    logic cmd_read;
    logic claim;
    logic xfer;
    logic wr_en;

    assign addr_phase = !FRAME && frame_prev_reg;
    assign addr_hit   = (AD[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]);
    assign cmd_write  = (CBE == 4'b0111);
    assign cmd_read   = (CBE == 4'b0110);
    assign claim      = (state_reg == IDLE) && addr_phase && addr_hit && (cmd_write || cmd_read);
    assign xfer       = ((state_reg == WR_DATA) || (state_reg == RD_DATA)) && !trdy_reg && !IRDY;
    assign wr_en      = xfer && (state_reg == WR_DATA);

    always_comb begin
        index_next = index_reg;
        if (claim)
            index_next = AD[DEPTH_LOG2+1:2];
        else if (xfer)
            index_next = index_reg + 1'b1;
    end

    // One byte-wide array per lane so byte enables map onto independent write ports.
    // Read address follows index_next so the word for the next data phase is ready one edge later.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [0:DEPTH-1];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge CLK) begin
                if (wr_en && !CBE[gi])
                    lane_mem[index_reg] <= AD[8*gi +: 8];
                rd_byte_reg <= lane_mem[index_next];
            end

            assign rd_word[8*gi +: 8] = rd_byte_reg;
        end
    endgenerate

`ifdef PCI_TARGET_DISCONNECT_EN
    logic stop_reg;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg      <= IDLE;
            index_reg      <= '0;
            // Cleared so a FRAME still low when reset lifts is not taken for a new address phase.
            frame_prev_reg <= 1'b0;
            trdy_reg       <= 1'b1;
            devsel_reg     <= 1'b1;
            ad_oe_reg      <= 1'b0;
`ifdef PCI_TARGET_DISCONNECT_EN
            stop_reg       <= 1'b1;
`endif
        end else begin
            frame_prev_reg <= FRAME;
            index_reg      <= index_next;
            case (state_reg)
                IDLE: begin
                    if (claim)
                        state_reg <= cmd_write ? WR_DATA : RD_TURN;
                end
                RD_TURN: begin
                    devsel_reg <= 1'b0;
                    state_reg  <= RD_DATA;
                end
                WR_DATA, RD_DATA: begin
                    // First cycle in each state: writes claim here, reads start driving AD here.
                    if (devsel_reg) begin
                        devsel_reg <= 1'b0;
                        trdy_reg   <= 1'b0;
                    end else if (trdy_reg) begin
                        trdy_reg  <= 1'b0;
                        ad_oe_reg <= 1'b1;
                    end else if (xfer) begin
                        if (FRAME)
                            state_reg <= TURN;
`ifdef PCI_TARGET_DISCONNECT_EN
                        else if (index_reg == LAST_INDEX) begin
                            state_reg <= DISC;
                            stop_reg  <= 1'b0;
                            trdy_reg  <= 1'b1;
                        end
`endif
                    end
                end
`ifdef PCI_TARGET_DISCONNECT_EN
                DISC: begin
                    if (FRAME) begin
                        state_reg  <= TURN;
                        stop_reg   <= 1'b1;
                        devsel_reg <= 1'b1;
                        ad_oe_reg  <= 1'b0;
                    end
                end
`endif
                TURN: begin
                    trdy_reg   <= 1'b1;
                    devsel_reg <= 1'b1;
                    ad_oe_reg  <= 1'b0;
                    state_reg  <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign TRDY   = trdy_reg;
    assign DEVSEL = devsel_reg;
    assign AD     = ad_oe_reg ? rd_word : {32{1'bz}};
`ifdef PCI_TARGET_DISCONNECT_EN
    assign STOP   = stop_reg;
`else
    assign STOP   = 1'b1;
`endif

endmodule

// File: tb/tb_pci_target_mem.sv
// Self-checking bench for pci_target_mem: a master model drives bursts, a scoreboard checks read data.
module tb_pci_target_mem;
    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        frame = 1'b1;
    logic        irdy  = 1'b1;
    logic        m_oe  = 1'b0;
    logic [31:0] m_ad  = 32'h0;
    logic [3:0]  cbe   = 4'hF;
    wire  [31:0] ad;
    logic        trdy;
    logic        devsel;
    logic        stop;

    assign ad = m_oe ? m_ad : {32{1'bz}};

    // Released AD floats high, so "AD=Z" reads as all ones.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_pu
            pullup (ad[gi]);
        end
    endgenerate

    pci_target_mem #(
        .BASE_ADDR (32'hFFFF_0000),
        .DEPTH_LOG2(4)
    ) dut (
        .CLK   (clk),
        .RST   (rst),
        .FRAME (frame),
        .AD    (ad),
        .CBE   (cbe),
        .IRDY  (irdy),
        .TRDY  (trdy),
        .DEVSEL(devsel),
        .STOP  (stop)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          fails  = 0;
    logic [31:0] exp_mem [16];
    logic [31:0] wd [16];
    logic [3:0]  wb [16];
    logic [31:0] exp_q [$];
    logic [31:0] obs_q [$];

    int          r_first;
    int          r_ncomp;
    bit          r_dev;
    bit          r_stop;
    logic [31:0] r_mid_ad;
    logic [31:0] r_wait_ad;
    logic        r_wait_trdy;
    logic        r_end_trdy;
    logic        r_end_devsel;
    logic        r_end_stop;
    logic [31:0] r_end_ad;

    // Master model: address phase, then n data phases with an optional single IRDY wait after wait_after transfers.
    task automatic bus_xact(input bit rd, input logic [31:0] addr, input int n,
                            input int wait_after, input int limit);
        int          cyc;
        int          k;
        bit          waited;
        bit          xfer;
        logic        t;
        logic [31:0] a;
        cyc = 0; k = 0; waited = 0;
        r_first = -1; r_ncomp = 0; r_dev = 0; r_stop = 0;
        r_mid_ad = 32'h0; r_wait_ad = 32'h0; r_wait_trdy = 1'b1;
        @(posedge clk); #1;
        frame = 1'b0; irdy = 1'b1; m_oe = 1'b1; m_ad = addr;
        cbe = rd ? 4'b0110 : 4'b0111;
        @(posedge clk); #1;
        irdy = 1'b0; frame = (n == 1);
        if (rd) begin
            m_oe = 1'b0; cbe = 4'h0;
        end else begin
            m_ad = wd[0]; cbe = wb[0];
        end
        while (k < n && cyc < limit && !r_stop) begin
            @(negedge clk);
            t = trdy; a = ad;
            if (devsel === 1'b0) r_dev = 1;
            if (stop === 1'b0) r_stop = 1;
            if (cyc == 1) r_mid_ad = a;
            if (irdy) begin
                r_wait_trdy = t; r_wait_ad = a;
            end
            @(posedge clk);
            cyc++;
            xfer = !irdy && (t === 1'b0);
            if (xfer) begin
                if (rd) obs_q.push_back(a);
                if (k == 0) r_first = cyc;
                k++;
            end
            #1;
            if (k < n) begin
                if (xfer && k == wait_after && !waited) begin
                    irdy = 1'b1; waited = 1;
                end else begin
                    irdy = 1'b0; frame = (k == n - 1);
                    if (!rd) begin
                        m_ad = wd[k]; cbe = wb[k];
                    end
                end
            end
        end
        r_ncomp = k;
        frame = 1'b1; irdy = 1'b1; m_oe = 1'b0; cbe = 4'hF;
        @(posedge clk);
        @(negedge clk);
        r_end_trdy = trdy; r_end_devsel = devsel; r_end_stop = stop; r_end_ad = ad;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (trdy !== 1'b1) begin fails++; $display("FAIL reset_trdy: got %b want 1", trdy); end
        checks++; if (devsel !== 1'b1) begin fails++; $display("FAIL reset_devsel: got %b want 1", devsel); end
        checks++; if (stop !== 1'b1) begin fails++; $display("FAIL reset_stop: got %b want 1", stop); end
        checks++; if (ad !== 32'hFFFF_FFFF) begin fails++; $display("FAIL reset_ad_released: got %h want ffffffff", ad); end
        $display("reset: trdy=%b devsel=%b stop=%b ad=%h", trdy, devsel, stop, ad);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            wd[i] = 32'hA5A5_0000 + 32'(i); wb[i] = 4'h0;
        end
        bus_xact(1'b0, 32'hFFFF_0000, 16, 99, 40);
        for (int i = 0; i < 16; i++) exp_mem[i] = 32'hA5A5_0000 + 32'(i);
        checks++; if (r_ncomp !== 16) begin fails++; $display("FAIL fill_count: got %0d want 16", r_ncomp); end
        checks++; if (r_stop !== 1'b0) begin fails++; $display("FAIL fill_no_stop: got stop seen %b want 0", r_stop); end
        $display("fill: %0d words written, stop_seen=%b", r_ncomp, r_stop);
    endtask

    task automatic test_write_burst();
        for (int i = 0; i < 7; i++) begin
            wd[i] = 32'h0000_F0F0 + 32'(i); wb[i] = 4'h0;
        end
        bus_xact(1'b0, 32'hFFFF_0005, 7, 3, 40);
        for (int i = 0; i < 7; i++) exp_mem[1 + i] = 32'h0000_F0F0 + 32'(i);
        checks++; if (r_first !== 2) begin fails++; $display("FAIL wr_first_latency: got %0d want 2", r_first); end
        checks++; if (r_ncomp !== 7) begin fails++; $display("FAIL wr_count: got %0d want 7", r_ncomp); end
        checks++; if (r_dev !== 1'b1) begin fails++; $display("FAIL wr_devsel_claim: got %b want 1", r_dev); end
        checks++; if (r_wait_trdy !== 1'b0) begin fails++; $display("FAIL wr_wait_trdy_hold: got %b want 0", r_wait_trdy); end
        checks++; if (r_end_trdy !== 1'b1) begin fails++; $display("FAIL wr_end_trdy: got %b want 1", r_end_trdy); end
        checks++; if (r_end_devsel !== 1'b1) begin fails++; $display("FAIL wr_end_devsel: got %b want 1", r_end_devsel); end
        $display("write_burst: first=%0d count=%0d wait_trdy=%b end trdy=%b devsel=%b",
                 r_first, r_ncomp, r_wait_trdy, r_end_trdy, r_end_devsel);
    endtask

    task automatic test_byte_enables();
        logic [31:0] e;
        logic [31:0] o;
        wd[0] = 32'h0000_0000; wb[0] = 4'h0;
        bus_xact(1'b0, 32'hFFFF_0000, 1, 99, 20);
        wd[0] = 32'hAABB_CCDD; wb[0] = 4'b1010;
        bus_xact(1'b0, 32'hFFFF_0000, 1, 99, 20);
        exp_mem[0] = 32'h00BB_00DD;
        exp_q.push_back(32'h00BB_00DD);
        bus_xact(1'b1, 32'hFFFF_0000, 1, 99, 20);
        checks++; if (r_first !== 3) begin fails++; $display("FAIL be_rd_latency: got %0d want 3", r_first); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                fails++; $display("FAIL be_data: got no word want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL be_data: got %h want %h", o, e); end
                $display("byte_enables: mem[0]=%h", o);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_read_burst();
        logic [31:0] e;
        logic [31:0] o;
        for (int i = 1; i <= 3; i++) exp_q.push_back(exp_mem[i]);
        bus_xact(1'b1, 32'hFFFF_0004, 3, 99, 40);
        checks++; if (r_mid_ad !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rd_turnaround_ad: got %h want ffffffff", r_mid_ad); end
        checks++; if (r_first !== 3) begin fails++; $display("FAIL rd_first_latency: got %0d want 3", r_first); end
        checks++; if (r_ncomp !== 3) begin fails++; $display("FAIL rd_count: got %0d want 3", r_ncomp); end
        checks++; if (r_end_ad !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rd_end_ad_released: got %h want ffffffff", r_end_ad); end
        checks++; if (r_end_trdy !== 1'b1) begin fails++; $display("FAIL rd_end_trdy: got %b want 1", r_end_trdy); end
        checks++; if (r_end_devsel !== 1'b1) begin fails++; $display("FAIL rd_end_devsel: got %b want 1", r_end_devsel); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                fails++; $display("FAIL rd_data: got no word want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL rd_data: got %h want %h", o, e); end
                $display("read_burst: word %h (expected %h)", o, e);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_addr_miss();
        wd[0] = 32'hDEAD_BEEF; wb[0] = 4'h0;
        bus_xact(1'b0, 32'h1234_0000, 1, 99, 6);
        checks++; if (r_dev !== 1'b0) begin fails++; $display("FAIL miss_devsel: got claim %b want 0", r_dev); end
        checks++; if (r_ncomp !== 0) begin fails++; $display("FAIL miss_count: got %0d want 0", r_ncomp); end
        $display("addr_miss: devsel_seen=%b transfers=%0d", r_dev, r_ncomp);
    endtask

    task automatic test_end_window();
        wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222; wd[2] = 32'h3333_3333;
        wb[0] = 4'h0; wb[1] = 4'h0; wb[2] = 4'h0;
        bus_xact(1'b0, 32'hFFFF_003C, 3, 99, 20);
`ifdef PCI_TARGET_DISCONNECT_EN
        exp_mem[15] = 32'h1111_1111;
        checks++; if (r_stop !== 1'b1) begin fails++; $display("FAIL eow_stop: got %b want 1", r_stop); end
        checks++; if (r_ncomp !== 1) begin fails++; $display("FAIL eow_count: got %0d want 1", r_ncomp); end
`else
        exp_mem[15] = 32'h1111_1111; exp_mem[0] = 32'h2222_2222; exp_mem[1] = 32'h3333_3333;
        checks++; if (r_stop !== 1'b0) begin fails++; $display("FAIL eow_stop: got %b want 0", r_stop); end
        checks++; if (r_ncomp !== 3) begin fails++; $display("FAIL eow_count: got %0d want 3", r_ncomp); end
`endif
        checks++; if (r_end_stop !== 1'b1) begin fails++; $display("FAIL eow_end_stop: got %b want 1", r_end_stop); end
        checks++; if (r_end_devsel !== 1'b1) begin fails++; $display("FAIL eow_end_devsel: got %b want 1", r_end_devsel); end
        $display("end_window: transfers=%0d stop_seen=%b end devsel=%b stop=%b",
                 r_ncomp, r_stop, r_end_devsel, r_end_stop);
    endtask

    task automatic test_readback(input string tag);
        logic [31:0] e;
        logic [31:0] o;
        for (int i = 0; i < 16; i++) exp_q.push_back(exp_mem[i]);
        bus_xact(1'b1, 32'hFFFF_0000, 16, 5, 60);
        checks++; if (r_ncomp !== 16) begin fails++; $display("FAIL %s_count: got %0d want 16", tag, r_ncomp); end
        checks++; if (r_wait_ad !== exp_mem[5]) begin fails++; $display("FAIL %s_wait_ad_hold: got %h want %h", tag, r_wait_ad, exp_mem[5]); end
        checks++; if (r_stop !== 1'b0) begin fails++; $display("FAIL %s_no_stop: got %b want 0", tag, r_stop); end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                fails++; $display("FAIL %s_data[%0d]: got no word want %h", tag, i, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL %s_data[%0d]: got %h want %h", tag, i, o, e); end
                $display("%s: mem[%0d]=%h (expected %h)", tag, i, o, e);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid_burst();
        int n;
        @(posedge clk); #1;
        frame = 1'b0; irdy = 1'b1; m_oe = 1'b1; m_ad = 32'hFFFF_0008; cbe = 4'b0110;
        @(posedge clk); #1;
        m_oe = 1'b0; irdy = 1'b0; cbe = 4'h0;
        n = 0;
        while (trdy !== 1'b0 && n < 10) begin
            @(negedge clk); n++;
        end
        @(posedge clk);
        @(negedge clk);
        checks++; if (trdy !== 1'b0) begin fails++; $display("FAIL mid_burst_active: got trdy %b want 0", trdy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (trdy !== 1'b1) begin fails++; $display("FAIL mid_rst_trdy: got %b want 1", trdy); end
        checks++; if (devsel !== 1'b1) begin fails++; $display("FAIL mid_rst_devsel: got %b want 1", devsel); end
        checks++; if (stop !== 1'b1) begin fails++; $display("FAIL mid_rst_stop: got %b want 1", stop); end
        checks++; if (ad !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mid_rst_ad: got %h want ffffffff", ad); end
        $display("reset_mid_burst: trdy=%b devsel=%b stop=%b ad=%h", trdy, devsel, stop, ad);
        frame = 1'b1; irdy = 1'b1; cbe = 4'hF;
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_burst();
        test_byte_enables();
        test_read_burst();
        test_addr_miss();
        test_end_window();
        test_readback("readback");
        test_reset_mid_burst();
        test_readback("post_reset");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pci_target_mem.md
# pci_target_mem

Parametrised PCI memory target: decodes a configurable address window, claims memory-read and memory-write transactions, and serves single or burst transfers from an internal word array. It is the next generation of the team's fixed-address PCI device model, adding a parametrised base/depth, per-byte write enables, wait-state handling on both sides, and an optional target disconnect at the end of the window. It sits on the shared AD bus beside other targets and is driven by the PCI master model or the bench.

## Interface
- BASE_ADDR, 32'hFFFF_0000, window base; must be aligned to 2^(DEPTH_LOG2+2) bytes
- DEPTH_LOG2, 4, log2 of the word count; the array holds 2^DEPTH_LOG2 32-bit words
- CLK  input  1  bus clock; all sampling on the rising edge
- RST  input  1  reset, asynchronous, active-high
- FRAME  input  1  active-low transaction framing
- AD  inout  32  multiplexed address/data
- CBE  input  4  command in the address phase; active-low byte enables in data phases
- IRDY  input  1  active-low initiator ready
- TRDY  output  1  active-low target ready
- DEVSEL  output  1  active-low device select
- STOP  output  1  active-low target stop

## Operation
- States: IDLE, WR_DATA, RD_TURN, RD_DATA, DISC, TURN.
- IDLE: an address phase is an edge where FRAME=0 and the previous sample of FRAME was 1. The target claims the transaction when AD[31:DEPTH_LOG2+2] matches BASE_ADDR and CBE is 4'b0111 (write) or 4'b0110 (read). Otherwise it stays in IDLE and drives no signal low.
- Word index is loaded from AD[DEPTH_LOG2+1:2]. AD[1:0] is ignored; bursts are linear.
- Write: the target moves to WR_DATA. On each edge with IRDY=0 and TRDY=0, bytes i with CBE[i]=0 are written at the current index and the index increments. CBE=4'b1111 writes nothing but still completes the data phase.
- Read: the target moves to RD_TURN for the mandatory turnaround, then to RD_DATA. It drives AD with mem[index], and on each edge with IRDY=0 and TRDY=0 it advances and presents the next word on the following cycle.
- An edge with IRDY=1 is an initiator wait state: the index holds, and AD and TRDY hold their values.
- A transfer with FRAME=1 is the final one. The target then enters TURN, releases DEVSEL, TRDY and AD, and returns to IDLE on the next edge.
- End of window:
  - Without the macro, the index wraps from 2^DEPTH_LOG2−1 to 0.
  - With the macro, see Configuration.
- Memory is not cleared by reset.

## Timing
- Reset values: TRDY=1, DEVSEL=1, STOP=1, AD output enable off (AD=Z), state IDLE. Assertion of RST takes effect immediately, including mid-burst.
- Address phase at edge N:
  - DEVSEL=0 after edge N+1.
  - Write: TRDY=0 after N+1, so the first data phase is sampled at N+2.
  - Read: AD is driven and TRDY=0 after N+2, so the first data phase is sampled at N+3.
- Zero target wait states inside a burst; one word per edge while IRDY=0.
- After the final transfer at edge M: TRDY=1 and DEVSEL=1 after M+1, and AD is released after M+1.
- FRAME=1 while IRDY=1 (protocol error) is ignored until the next completed transfer.

## Configuration
- PCI_TARGET_DISCONNECT_EN, defined:
  - When the transfer at index 2^DEPTH_LOG2−1 completes with FRAME=0, the target enters DISC.
  - In DISC: STOP=0, TRDY=1, DEVSEL=0, and no further data moves.
  - On the first edge with FRAME=1, the target enters TURN, STOP=1 and DEVSEL=1, and AD is released.
  - A final transfer at the last index ends normally, without STOP.
- PCI_TARGET_DISCONNECT_EN, undefined: STOP is tied to 1 and the index wraps.

## Test plan
- Reset: hold RST=1 for two edges, then release -> TRDY, DEVSEL and STOP are all 1 and AD=Z.
- Write burst: address 32'hFFFF_0005 with CBE=0111, then data 32'h0000_F0F0..F0F6 with one IRDY=1 wait after the third word and FRAME=1 on the last word -> mem[1..7] = F0F0..F0F6, and DEVSEL/TRDY deassert one cycle after the last word.
- Byte enables: write 32'hAABB_CCDD to index 0 with CBE=4'b1010 over an old value of 32'h0000_0000 -> mem[0] = 32'h00BB_00DD.
- Read burst: address 32'hFFFF_0004 with CBE=0110 for three words -> AD=Z at N+1, then mem[1], mem[2], mem[3] returned on edges N+3..N+5, and AD is released after the final transfer.
- Address miss: address 32'h1234_0000 -> DEVSEL stays 1 for the whole transaction and memory is unchanged.
- End of window: write burst starting at index 15 for three words.
  - With the macro: STOP=0 after the first word; only mem[15] is written.
  - Without the macro: mem[15], mem[0] and mem[1] are written.
  - A separate run asserts RST mid-burst -> outputs return to reset values at once.
